mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between two requesters: the instruction-fetch

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: the fetch (IF) and load/store (DM)
// requester ports plus the single-port memory port.
//   slave  : arbiter view (takes requests and read data, drives grants and memory strobes)
//   master : environment view (requesters and memory model)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// fetch stage (IF) and the load/store stage (DM). DM has fixed priority;
// after STARVE_MAX consecutive IF losses the next grant goes to IF.
// Each transaction occupies the memory for MEM_LAT cycles after issue.
//
// Optional feature macro: ARB_BACK_TO_BACK_EN
//   defined     : a new transaction may issue in the response cycle
//                 (one transaction every MEM_LAT cycles)
//   not defined : issue only from IDLE (one every MEM_LAT+1 cycles)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | memory free; any request is issued combinationally
// S_WAIT | transaction in flight; cnt counts down to the response cycle
module mem_port_arbiter #(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] starve_q, starve_d;
   logic       owner_dm_q, owner_dm_d;
   logic       we_q, we_d;

   logic       rsp_cycle;
   logic       issue_ok;
   logic       pick_if;
   logic       pick_dm;
   logic       issue;

   // state register; reset abandons any in-flight transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         starve_q   <= '0;
         owner_dm_q <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         owner_dm_q <= owner_dm_d;
         we_q       <= we_d;
      end
   end

   // winner selection, issue, response routing and next-state logic
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      starve_d      = starve_q;
      owner_dm_d    = owner_dm_q;
      we_d          = we_q;
      bus.if_gnt    = 1'b0;
      bus.if_rvalid = 1'b0;
      bus.if_rdata  = '0;
      bus.dm_gnt    = 1'b0;
      bus.dm_rvalid = 1'b0;
      bus.dm_rdata  = '0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.busy      = 1'b0;

      rsp_cycle = (state_q == S_WAIT) && (cnt_q == 4'd1);
`ifdef ARB_BACK_TO_BACK_EN
      issue_ok  = (state_q == S_IDLE) || rsp_cycle;
`else
      issue_ok  = (state_q == S_IDLE);
`endif
      pick_if   = bus.if_req && (!bus.dm_req || (starve_q == 4'(STARVE_MAX)));
      pick_dm   = bus.dm_req && !pick_if;
      issue     = !rst && issue_ok && (pick_if || pick_dm);

      // everything stays quiet in a reset cycle, including a pending response
      if (!rst) begin
         bus.busy = (state_q == S_WAIT);

         if (rsp_cycle) begin
            state_d = S_IDLE;
            if (owner_dm_q) begin
               bus.dm_rvalid = 1'b1;
               bus.dm_rdata  = we_q ? '0 : bus.mem_rdata;
            end else begin
               bus.if_rvalid = 1'b1;
               bus.if_rdata  = bus.mem_rdata;
            end
         end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 4'd1;
         end

         if (issue) begin
            bus.mem_en = 1'b1;
            state_d    = S_WAIT;
            cnt_d      = 4'(MEM_LAT);
            owner_dm_d = pick_dm;
            if (pick_dm) begin
               bus.dm_gnt   = 1'b1;
               bus.mem_we   = bus.dm_we;
               bus.mem_addr = bus.dm_addr;
               we_d         = bus.dm_we;
               if (bus.dm_we) begin
                  bus.mem_wdata = bus.dm_wdata;
               end
            end else begin
               bus.if_gnt   = 1'b1;
               bus.mem_addr = bus.if_addr;
               we_d         = 1'b0;
            end
         end

         if (!bus.if_req || (issue && pick_if)) begin
            starve_d = '0;
         end else if (issue && pick_dm && (starve_q != 4'(STARVE_MAX))) begin
            starve_d = starve_q + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int MEM_LAT    = 1;
   localparam int STARVE_MAX = 4;
`ifdef ARB_BACK_TO_BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // memory model: single-port, one cycle read latency, preloaded with word i = i
   logic [31:0] mem_array [256];
   logic        preload;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem_array[i] <= 32'(i);
         bus.mem_rdata <= '0;
      end else if (bus.mem_en) begin
         if (bus.mem_we) mem_array[bus.mem_addr[7:0]] <= bus.mem_wdata;
         else            bus.mem_rdata <= mem_array[bus.mem_addr[7:0]];
      end
   end

   // reference model: port free time, pending response, starvation count
   int          cyc;
   int          free_at;
   int          last_issue;
   bit          resp_valid;
   int          resp_cycle;
   bit          resp_dm;
   logic [31:0] resp_data;
   int          starve;
   logic [31:0] ref_mem [256];

   bit          m_rst, m_iq, m_dq, m_we;
   logic [31:0] m_ia, m_da, m_dw;
   bit          m_iss, m_win_if, m_win_dm, m_rv;

   logic [134:0] exp_vec, obs_vec;
   int checks;
   int errors;

   task automatic apply(input bit r, input bit iq, input logic [31:0] ia,
                        input bit dq, input bit dwe, input logic [31:0] da,
                        input logic [31:0] dw);
      bit          e_busy, e_if_rv, e_dm_rv;
      logic [31:0] e_addr;
      @(negedge clk);
      rst = r;
      bus.if_req = iq;  bus.if_addr = ia;
      bus.dm_req = dq;  bus.dm_we = dwe;  bus.dm_addr = da;  bus.dm_wdata = dw;
      m_rst = r; m_iq = iq; m_ia = ia; m_dq = dq; m_we = dwe; m_da = da; m_dw = dw;
      #1;
      m_iss    = !r && (iq || dq) && (cyc >= free_at);
      m_win_if = m_iss && iq && (!dq || starve == STARVE_MAX);
      m_win_dm = m_iss && !m_win_if;
      m_rv     = !r && resp_valid && (resp_cycle == cyc);
      e_if_rv  = m_rv && !resp_dm;
      e_dm_rv  = m_rv && resp_dm;
      e_busy   = !r && (cyc > last_issue) && (cyc <= last_issue + MEM_LAT);
      e_addr   = m_win_if ? ia : (m_win_dm ? da : 32'h0);
      exp_vec  = {m_win_if, e_if_rv, (e_if_rv ? resp_data : 32'h0),
                  m_win_dm, e_dm_rv, (e_dm_rv ? resp_data : 32'h0),
                  m_iss, (m_win_dm && dwe), e_addr,
                  ((m_win_dm && dwe) ? dw : 32'h0), e_busy};
      obs_vec  = {bus.if_gnt, bus.if_rvalid, bus.if_rdata,
                  bus.dm_gnt, bus.dm_rvalid, bus.dm_rdata,
                  bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy};
   endtask

   task automatic advance();
      @(posedge clk);
      if (m_rst) begin
         resp_valid = 1'b0;
         last_issue = -100;
         free_at    = cyc + 1;
         starve     = 0;
      end else begin
         if (m_rv) resp_valid = 1'b0;
         if (m_iss) begin
            last_issue = cyc;
            free_at    = cyc + MEM_LAT + (B2B ? 0 : 1);
            resp_valid = 1'b1;
            resp_cycle = cyc + MEM_LAT;
            resp_dm    = m_win_dm;
            if (m_win_dm && m_we) begin
               resp_data = 32'h0;
               ref_mem[m_da[7:0]] = m_dw;
            end else begin
               resp_data = ref_mem[m_win_dm ? m_da[7:0] : m_ia[7:0]];
            end
         end
         if (!m_iq || m_win_if) starve = 0;
         else if (m_win_dm && starve < STARVE_MAX) starve++;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         apply(0, 0, 0, 0, 0, 0, 0);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         advance();
      end
   endtask

   task automatic test_reset();
      preload = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply(1, 1, 32'h8, 1, 1, 32'h9, 32'h55);
         checks++;
         if (obs_vec !== 135'h0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, obs_vec);
         end
         advance();
         preload = 1'b0;
      end
   endtask

   task automatic test_if_fetch();
      apply(0, 1, 32'h4, 0, 0, 0, 0);
      checks++;
      if ({bus.if_gnt, bus.mem_en, bus.mem_addr} !== {1'b1, 1'b1, 32'h4} || obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL if_fetch_issue got=%h exp=%h", obs_vec, exp_vec);
      end
      advance();
      apply(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h4} || obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL if_fetch_data got=%h exp=%h", obs_vec, exp_vec);
      end
      advance();
      idle(2);
   endtask

   task automatic test_priority();
      apply(0, 1, 32'h8, 1, 0, 32'h10, 0);
      checks++;
      if ({bus.dm_gnt, bus.if_gnt} !== 2'b10 || obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL prio_dm_first got=%h exp=%h", obs_vec, exp_vec);
      end
      advance();
      apply(0, 1, 32'h8, 0, 0, 0, 0);
      checks++;
      if ({bus.dm_rvalid, bus.dm_rdata, bus.if_gnt} !== {1'b1, 32'h10, B2B} || obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL prio_dm_data got=%h exp=%h", obs_vec, exp_vec);
      end
      advance();
      apply(0, !B2B, 32'h8, 0, 0, 0, 0);
      checks++;
      if (bus.if_gnt !== !B2B || obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL prio_if_after got=%h exp=%h", obs_vec, exp_vec);
      end
      advance();
      idle(2);
   endtask

   task automatic test_starvation();
      logic [5:0] seq;
      int         n;
      seq = '0;
      n   = 0;
      for (int i = 0; i < 20 && n < 6; i++) begin
         apply(0, 1, 32'h3, 1, 0, 32'h7, 0);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL starve_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         if (bus.if_gnt || bus.dm_gnt) begin
            seq = {seq[4:0], bus.if_gnt};
            n++;
         end
         advance();
      end
      checks++;
      if (seq !== 6'b000010 || n != 6) begin
         errors++;
         $display("FAIL starve_sequence got=%b (%0d grants) exp=000010 (6 grants)", seq, n);
      end
      idle(2);
   endtask

   task automatic test_store_load();
      int we_cycles;
      we_cycles = 0;
      apply(0, 0, 0, 1, 1, 32'h20, 32'hDEAD);
      if (bus.mem_we) we_cycles++;
      checks++;
      if (obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL store_issue got=%h exp=%h", obs_vec, exp_vec);
      end
      advance();
      apply(0, 0, 0, 0, 0, 0, 0);
      if (bus.mem_we) we_cycles++;
      checks++;
      if ({bus.dm_rvalid, bus.dm_rdata} !== {1'b1, 32'h0} || obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL store_done got=%h exp=%h", obs_vec, exp_vec);
      end
      advance();
      apply(0, 0, 0, 0, 0, 0, 0);
      if (bus.mem_we) we_cycles++;
      advance();
      checks++;
      if (we_cycles != 1) begin
         errors++;
         $display("FAIL store_we_width got=%0d exp=1", we_cycles);
      end
      apply(0, 0, 0, 1, 0, 32'h20, 0);
      advance();
      apply(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({bus.dm_rvalid, bus.dm_rdata} !== {1'b1, 32'hDEAD} || obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL load_after_store got=%h exp=%h", obs_vec, exp_vec);
      end
      advance();
      idle(2);
   endtask

   task automatic test_reset_wait();
      apply(0, 1, 32'h30, 0, 0, 0, 0);
      advance();
      apply(1, 1, 32'h30, 1, 0, 32'h31, 0);
      checks++;
      if ({bus.if_rvalid, bus.dm_rvalid, bus.if_gnt, bus.dm_gnt} !== 4'b0 || obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL rst_in_wait got=%h exp=%h", obs_vec, exp_vec);
      end
      advance();
      apply(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_vec !== 135'h0 || obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL rst_after_wait got=%h exp=0", obs_vec);
      end
      advance();
      idle(2);
   endtask

   task automatic test_back_to_back();
      int grants;
      grants = 0;
      for (int i = 0; i < 10; i++) begin
         apply(0, 0, 0, 1, 0, 32'(i), 0);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL b2b_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         if (bus.dm_gnt) grants++;
         advance();
      end
      checks++;
      if (grants != (B2B ? 10 : 5)) begin
         errors++;
         $display("FAIL b2b_grant_count got=%0d exp=%0d", grants, (B2B ? 10 : 5));
      end
      idle(3);
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         apply(($urandom_range(0, 49) == 0),
               ($urandom_range(0, 9) < 6), 32'($urandom_range(0, 255)),
               ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 255)), $urandom);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         advance();
      end
      idle(3);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      cyc        = 0;
      free_at    = 0;
      last_issue = -100;
      resp_valid = 1'b0;
      resp_cycle = 0;
      resp_dm    = 1'b0;
      resp_data  = '0;
      starve     = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
      preload       = 1'b1;
      rst           = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.dm_req    = 1'b0;
      bus.dm_we     = 1'b0;
      bus.dm_addr   = '0;
      bus.dm_wdata  = '0;

      test_reset();
      test_if_fetch();
      test_priority();
      test_starvation();
      test_store_load();
      test_reset_wait();
      test_back_to_back();
      test_random();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
